uart_rx_async: RTL

//  Asynchronous UART receiver and companion to the transmit state machine. It takes
//  a serial line oversampled by a 16x baud enable and recovers start, 7/8 data bits,

---
 rtl/uart_rx_async.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_async.sv
// UART receiver: 16x oversampled start/data/parity/stop recovery into a holding register or an external FIFO.
// Optional stop-bit framing check is compiled in with `define COREUART_RX_FRAMING_ERR_EN.
module uart_rx_async #(
    parameter int RX_FIFO = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    output logic [7:0] rx_byte,
    output logic       rxrdy,
    output logic       fifo_write_rx,
    output logic       parity_err,
    output logic       overflow,
    output logic       framing_err
);

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    rx_state_t  state_q, state_d;
    logic       rx_meta_q, rx_s_q;
    logic [3:0] count_q, count_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic [7:0] data_q, data_d;
    logic       armed_q, armed_d;
    logic       bit8_q, bit8_d;
    logic       par_en_q, par_en_d;
    logic       par_bad_q, par_bad_d;
    logic       done_q, done_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rxrdy_q, rxrdy_d;
    logic       fifo_write_rx_q, fifo_write_rx_d;
    logic       parity_err_q, parity_err_d;
    logic       overflow_q, overflow_d;
    logic [3:0] last_bit;

`ifdef COREUART_RX_FRAMING_ERR_EN
    logic       stop_bad_q, stop_bad_d;
    logic       framing_err_q, framing_err_d;
`endif

    assign last_bit = bit8_q ? 4'd7 : 4'd6;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q       <= 1'b1;
            rx_s_q          <= 1'b1;
            state_q         <= RX_IDLE;
            count_q         <= 4'd0;
            bit_idx_q       <= 4'd0;
            data_q          <= 8'd0;
            armed_q         <= 1'b0;
            bit8_q          <= 1'b0;
            par_en_q        <= 1'b0;
            par_bad_q       <= 1'b0;
            done_q          <= 1'b0;
            rx_byte_q       <= 8'd0;
            rxrdy_q         <= 1'b0;
            fifo_write_rx_q <= 1'b1;
            parity_err_q    <= 1'b0;
            overflow_q      <= 1'b0;
`ifdef COREUART_RX_FRAMING_ERR_EN
            stop_bad_q      <= 1'b0;
            framing_err_q   <= 1'b0;
`endif
        end else begin
            rx_meta_q       <= rx;
            rx_s_q          <= rx_meta_q;
            state_q         <= state_d;
            count_q         <= count_d;
            bit_idx_q       <= bit_idx_d;
            data_q          <= data_d;
            armed_q         <= armed_d;
            bit8_q          <= bit8_d;
            par_en_q        <= par_en_d;
            par_bad_q       <= par_bad_d;
            done_q          <= done_d;
            rx_byte_q       <= rx_byte_d;
            rxrdy_q         <= rxrdy_d;
            fifo_write_rx_q <= fifo_write_rx_d;
            parity_err_q    <= parity_err_d;
            overflow_q      <= overflow_d;
`ifdef COREUART_RX_FRAMING_ERR_EN
            stop_bad_q      <= stop_bad_d;
            framing_err_q   <= framing_err_d;
`endif
        end
    end

    // Frame sequencing; only advances on the 16x baud enable.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        armed_d   = armed_q;
        bit8_d    = bit8_q;
        par_en_d  = par_en_q;
        par_bad_d = par_bad_q;
        done_d    = 1'b0;
`ifdef COREUART_RX_FRAMING_ERR_EN
        stop_bad_d = stop_bad_q;
`endif
        if (baud_clock) begin
            case (state_q)
                RX_IDLE: begin
                    if (rx_s_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = RX_START;
                        count_d = 4'd0;
                    end
                end
                RX_START: begin
                    if (count_q == 4'd7) begin
                        if (!rx_s_q) begin
                            state_d   = RX_DATA;
                            count_d   = 4'd0;
                            bit_idx_d = 4'd0;
                            data_d    = 8'd0;
                            bit8_d    = bit8;
                            par_en_d  = parity_en;
                            par_bad_d = 1'b0;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
                RX_DATA: begin
                    count_d = count_q + 4'd1;
                    if (count_q == 4'd15) begin
                        data_d[bit_idx_q[2:0]] = rx_s_q;
                        if (bit_idx_q == last_bit) begin
                            state_d = par_en_q ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 4'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    count_d = count_q + 4'd1;
                    if (count_q == 4'd15) begin
                        // bit 7 is still zero in 7-bit mode, so the full-byte XOR is valid.
                        par_bad_d = (rx_s_q != (odd_n_even ^ (^data_q)));
                        state_d   = RX_STOP;
                    end
                end
                RX_STOP: begin
                    count_d = count_q + 4'd1;
                    if (count_q == 4'd15) begin
                        done_d  = 1'b1;
                        state_d = RX_IDLE;
                        armed_d = 1'b0;
`ifdef COREUART_RX_FRAMING_ERR_EN
                        stop_bad_d = !rx_s_q;
`endif
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase
        end
    end

    // Delivery and sticky flags; a completion on the same clk as a read wins over the clear.
    always_comb begin
        rx_byte_d       = rx_byte_q;
        rxrdy_d         = rxrdy_q;
        fifo_write_rx_d = 1'b1;
        parity_err_d    = parity_err_q;
        overflow_d      = overflow_q;
`ifdef COREUART_RX_FRAMING_ERR_EN
        framing_err_d   = framing_err_q;
`endif
        if (read_rx_byte) begin
            rxrdy_d      = 1'b0;
            parity_err_d = 1'b0;
            overflow_d   = 1'b0;
`ifdef COREUART_RX_FRAMING_ERR_EN
            framing_err_d = 1'b0;
`endif
        end
        if (done_q) begin
            rx_byte_d = data_q;
            if (RX_FIFO == 0) begin
                rxrdy_d = 1'b1;
                if (rxrdy_q && !read_rx_byte) begin
                    overflow_d = 1'b1;
                end
            end else begin
                if (!fifo_full) begin
                    fifo_write_rx_d = 1'b0;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            if (par_en_q && par_bad_q) begin
                parity_err_d = 1'b1;
            end
`ifdef COREUART_RX_FRAMING_ERR_EN
            if (stop_bad_q) begin
                framing_err_d = 1'b1;
            end
`endif
        end
    end

    generate
        if (RX_FIFO != 0) begin : g_fifo_rdy
            assign rxrdy = !fifo_empty;
        end else begin : g_reg_rdy
            assign rxrdy = rxrdy_q;
        end
    endgenerate

    // Inputs/flops that one of the build variants leaves without a reader.
    logic unused_sink;
    assign unused_sink = ^{fifo_full, fifo_empty, rxrdy_q};

    assign rx_byte       = rx_byte_q;
    assign fifo_write_rx = fifo_write_rx_q;
    assign parity_err    = parity_err_q;
    assign overflow      = overflow_q;

`ifdef COREUART_RX_FRAMING_ERR_EN
    assign framing_err = framing_err_q;
`else
    assign framing_err = 1'b0;
`endif

endmodule
